// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the CPU load/store path and a
// debug/loader port. Every access runs IDLE -> ISSUE -> (WAIT) -> DONE:
// the winner's command is registered at sampling, presented on mem_* for one
// cycle, read data is captured after RD_LAT cycles, and completion is
// signalled in DONE. DONE also samples new requests, so accesses can run
// back to back. Ties go round-robin on last_owner. dbg_halt locks the CPU out
// of memory once any CPU access already in flight has finished.
//
// Ports
//   clk, reset        clock (clk_slow domain), synchronous active-low reset
//   cpu_cs/cpu_rw_    CPU request (level, held until cpu_ack) and direction
//   cpu_addr/wdata    CPU command
//   cpu_rdata/ack     CPU read data, one-cycle completion pulse
//   cpu_stall         combinational freeze for the CPU pipeline
//   dbg_req/dbg_rw_   debug request (level, held until dbg_gnt) and direction
//   dbg_addr/wdata    debug command
//   dbg_gnt           one-cycle pulse in the debug access's issue cycle
//   dbg_rdata/rvalid  debug read data, one-cycle valid pulse
//   dbg_halt/halted   host lock-out request / CPU locked out and idle
//   mem_*             single-port memory interface (rd latency RD_LAT)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1      // legal 1..7
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_cs,
    input  logic              cpu_rw_,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,

    input  logic              dbg_req,
    input  logic              dbg_rw_,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,

    input  logic              dbg_halt,
    output logic              halted,

    output logic              mem_cs,
    output logic              mem_rw_,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic       {OWN_CPU, OWN_DBG}        owner_t;

    state_t            state,     state_n;
    owner_t            owner,     owner_n;    // owner of current access == last_owner
    logic              cmd_rw_,   cmd_rw_n;
    logic [ADDR_W-1:0] cmd_addr,  cmd_addr_n;
    logic [DATA_W-1:0] cmd_wdata, cmd_wdata_n;
    logic [2:0]        lat_cnt,   lat_cnt_n;

    logic cpu_elig;
    logic dbg_elig;
    logic rd_capture;
    logic halted_n;

    // Completion and issue strobes are decoded straight from the state
    // register, so they are glitch-free and drop as soon as reset takes hold.
    assign mem_cs     = (state == ISSUE);
    assign mem_rw_    = (state == ISSUE) ? cmd_rw_ : 1'b1;
    assign mem_addr   = cmd_addr;
    assign mem_wdata  = cmd_wdata;
    assign dbg_gnt    = (state == ISSUE) && (owner == OWN_DBG);
    assign cpu_ack    = (state == DONE)  && (owner == OWN_CPU);
    assign dbg_rvalid = (state == DONE)  && (owner == OWN_DBG) && cmd_rw_;
    assign cpu_stall  = cpu_cs & ~cpu_ack;

    // The CPU still holds cpu_cs during its own ack cycle; masking it there
    // stops the same request from being serviced twice.
    assign cpu_elig   = cpu_cs & ~dbg_halt & ~cpu_ack;
    assign dbg_elig   = dbg_req;
    assign rd_capture = (state == WAIT) && (lat_cnt == 3'd1);

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_n     = state;
        owner_n     = owner;
        cmd_rw_n    = cmd_rw_;
        cmd_addr_n  = cmd_addr;
        cmd_wdata_n = cmd_wdata;
        lat_cnt_n   = lat_cnt;

        unique case (state)
            IDLE, DONE: begin
                if (cpu_elig && (!dbg_elig || owner == OWN_DBG)) begin
                    owner_n     = OWN_CPU;
                    cmd_rw_n    = cpu_rw_;
                    cmd_addr_n  = cpu_addr;
                    cmd_wdata_n = cpu_wdata;
                    state_n     = ISSUE;
                end else if (dbg_elig) begin
                    owner_n     = OWN_DBG;
                    cmd_rw_n    = dbg_rw_;
                    cmd_addr_n  = dbg_addr;
                    cmd_wdata_n = dbg_wdata;
                    state_n     = ISSUE;
                end else begin
                    state_n     = IDLE;
                end
            end
            ISSUE: begin
                if (cmd_rw_) begin
                    lat_cnt_n = 3'(RD_LAT);
                    state_n   = WAIT;
                end else begin
                    state_n   = DONE;
                end
            end
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_n = DONE;
                end else begin
                    lat_cnt_n = lat_cnt - 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Judged on the next state so halted rises in the cycle right after
        // the last CPU DONE rather than one cycle later.
        halted_n = dbg_halt & ~((state_n != IDLE) && (owner_n == OWN_CPU));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= IDLE;
            owner     <= OWN_DBG;       // CPU wins the first tie
            cmd_rw_   <= 1'b1;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            lat_cnt   <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            cmd_rw_   <= cmd_rw_n;
            cmd_addr  <= cmd_addr_n;
            cmd_wdata <= cmd_wdata_n;
            lat_cnt   <= lat_cnt_n;
            halted    <= halted_n;
            if (rd_capture) begin
                if (owner == OWN_CPU) begin
                    cpu_rdata <= mem_rdata;
                end else begin
                    dbg_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Two arbiter instances: index 0 with RD_LAT=1 and index 1 with RD_LAT=3,
// each with its own behavioural memory. Stimulus pushes the expected
// mem_cs / dbg_gnt / cpu_ack / dbg_rvalid events (with their cycle numbers)
// into queues; a negedge monitor pops and compares whenever one appears.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct {
        int          dut;
        int          cyc;
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic reset;

    logic        cpu_cs    [2];
    logic        cpu_rw_   [2];
    logic [7:0]  cpu_addr  [2];
    logic [15:0] cpu_wdata [2];
    logic [15:0] cpu_rdata [2];
    logic        cpu_ack   [2];
    logic        cpu_stall [2];
    logic        dbg_req   [2];
    logic        dbg_rw_   [2];
    logic [7:0]  dbg_addr  [2];
    logic [15:0] dbg_wdata [2];
    logic        dbg_gnt   [2];
    logic [15:0] dbg_rdata [2];
    logic        dbg_rvalid[2];
    logic        dbg_halt  [2];
    logic        halted    [2];
    logic        mem_cs    [2];
    logic        mem_rw_   [2];
    logic [7:0]  mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;

    exp_t q_mem[$];
    exp_t q_gnt[$];
    exp_t q_ack[$];
    exp_t q_rv[$];
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs[0]), .cpu_rw_(cpu_rw_[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
        .cpu_stall(cpu_stall[0]),
        .dbg_req(dbg_req[0]), .dbg_rw_(dbg_rw_[0]), .dbg_addr(dbg_addr[0]),
        .dbg_wdata(dbg_wdata[0]), .dbg_gnt(dbg_gnt[0]), .dbg_rdata(dbg_rdata[0]),
        .dbg_rvalid(dbg_rvalid[0]),
        .dbg_halt(dbg_halt[0]), .halted(halted[0]),
        .mem_cs(mem_cs[0]), .mem_rw_(mem_rw_[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs[1]), .cpu_rw_(cpu_rw_[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
        .cpu_stall(cpu_stall[1]),
        .dbg_req(dbg_req[1]), .dbg_rw_(dbg_rw_[1]), .dbg_addr(dbg_addr[1]),
        .dbg_wdata(dbg_wdata[1]), .dbg_gnt(dbg_gnt[1]), .dbg_rdata(dbg_rdata[1]),
        .dbg_rvalid(dbg_rvalid[1]),
        .dbg_halt(dbg_halt[1]), .halted(halted[1]),
        .mem_cs(mem_cs[1]), .mem_rw_(mem_rw_[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Behavioural memories: read data appears RD_LAT cycles after mem_cs,
    // filler 16'hDEAD otherwise so a mistimed capture is visible.
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] p0;
    logic [15:0] p1 [3];

    always @(posedge clk) begin
        if (cyc == 0) begin
            mem0[8'h40] <= 16'h1234;
            mem1[8'h55] <= 16'hA5A5;
            mem1[8'h56] <= 16'h0F0F;
        end
        if (mem_cs[0] && !mem_rw_[0]) mem0[mem_addr[0]] <= mem_wdata[0];
        if (mem_cs[1] && !mem_rw_[1]) mem1[mem_addr[1]] <= mem_wdata[1];
        p0    <= (mem_cs[0] && mem_rw_[0]) ? mem0[mem_addr[0]] : 16'hDEAD;
        p1[0] <= (mem_cs[1] && mem_rw_[1]) ? mem1[mem_addr[1]] : 16'hDEAD;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign mem_rdata[0] = p0;
    assign mem_rdata[1] = p1[2];

    function automatic logic [63:0] pack(input int d, input int c, input logic rw,
                                         input logic [7:0] a, input logic [15:0] dat);
        return {8'(d), 16'(c), 15'd0, rw, a, dat};
    endfunction

    function automatic exp_t ev(input int d, input int c, input logic rw,
                                input logic [7:0] a, input logic [15:0] dat);
        exp_t e;
        e.dut = d; e.cyc = c; e.rw = rw; e.addr = a; e.data = dat;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got %h, expected no such event (cycle %0d)", name, act, cyc);
    endtask

    // Packed layout: {dut, cycle, 15'b0, rw, addr, data}
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (mem_cs[d]) begin
                    if (q_mem.size() == 0)
                        fail_now("mem_cs", pack(d, cyc, mem_rw_[d], mem_addr[d], mem_wdata[d]));
                    else begin
                        mon_e = q_mem.pop_front();
                        check("mem_cs", pack(d, cyc, mem_rw_[d], mem_addr[d],
                                             mem_rw_[d] ? 16'h0 : mem_wdata[d]),
                              pack(mon_e.dut, mon_e.cyc, mon_e.rw, mon_e.addr, mon_e.data));
                    end
                end
                if (dbg_gnt[d]) begin
                    if (q_gnt.size() == 0) fail_now("dbg_gnt", pack(d, cyc, 1'b0, 8'h0, 16'h0));
                    else begin
                        mon_e = q_gnt.pop_front();
                        check("dbg_gnt", pack(d, cyc, 1'b0, 8'h0, 16'h0),
                              pack(mon_e.dut, mon_e.cyc, 1'b0, 8'h0, 16'h0));
                    end
                end
                if (cpu_ack[d]) begin
                    if (q_ack.size() == 0) fail_now("cpu_ack", pack(d, cyc, 1'b0, 8'h0, cpu_rdata[d]));
                    else begin
                        mon_e = q_ack.pop_front();
                        check("cpu_ack", pack(d, cyc, 1'b0, 8'h0, cpu_rdata[d]),
                              pack(mon_e.dut, mon_e.cyc, 1'b0, 8'h0, mon_e.data));
                    end
                end
                if (dbg_rvalid[d]) begin
                    if (q_rv.size() == 0) fail_now("dbg_rvalid", pack(d, cyc, 1'b0, 8'h0, dbg_rdata[d]));
                    else begin
                        mon_e = q_rv.pop_front();
                        check("dbg_rvalid", pack(d, cyc, 1'b0, 8'h0, dbg_rdata[d]),
                              pack(mon_e.dut, mon_e.cyc, 1'b0, 8'h0, mon_e.data));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            cpu_cs[d] = 1'b0; cpu_rw_[d] = 1'b1; cpu_addr[d] = 8'h0; cpu_wdata[d] = 16'h0;
            dbg_req[d] = 1'b0; dbg_rw_[d] = 1'b1; dbg_addr[d] = 8'h0; dbg_wdata[d] = 16'h0;
            dbg_halt[d] = 1'b0;
        end
    endtask

    task automatic wait_gnt(input int d);
        int n;
        n = 0;
        while (!dbg_gnt[d] && n < 20) begin
            tick();
            n++;
        end
        if (!dbg_gnt[d]) fail_now("dbg_gnt timeout", 64'(n));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Safety net: the run must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int nc;
        int nd;
        int n;

        idle_inputs();
        reset = 1'b0;
        repeat (2) tick();
        mon_en = 1'b1;

        // Reset holds everything quiet even with both requesters active.
        cpu_cs[0] = 1'b1; cpu_rw_[0] = 1'b0; dbg_req[0] = 1'b1;
        repeat (2) tick();
        check("rst mem_cs",    64'(mem_cs[0]),    64'd0);
        check("rst mem_rw_",   64'(mem_rw_[0]),   64'd1);
        check("rst cpu_ack",   64'(cpu_ack[0]),   64'd0);
        check("rst dbg_gnt",   64'(dbg_gnt[0]),   64'd0);
        check("rst halted",    64'(halted[0]),    64'd0);
        check("rst cpu_rdata", 64'(cpu_rdata[0]), 64'd0);
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();

        // CPU write 0x12 <= 0xBEEF: issue t+1, ack t+2, exactly one write.
        cpu_cs[0] = 1'b1; cpu_rw_[0] = 1'b0; cpu_addr[0] = 8'h12; cpu_wdata[0] = 16'hBEEF;
        t = cyc;
        q_mem.push_back(ev(0, t + 1, 1'b0, 8'h12, 16'hBEEF));
        q_ack.push_back(ev(0, t + 2, 1'b0, 8'h0, 16'h0000));
        tick();
        check("wr stall issue", 64'(cpu_stall[0]), 64'd1);
        tick();
        check("wr stall ack", 64'(cpu_stall[0]), 64'd0);
        cpu_cs[0] = 1'b0;
        repeat (4) tick();

        // Debug read 0x40 (RD_LAT=1): gnt t+1, data t+2, rvalid t+3.
        dbg_req[0] = 1'b1; dbg_rw_[0] = 1'b1; dbg_addr[0] = 8'h40;
        t = cyc;
        q_mem.push_back(ev(0, t + 1, 1'b1, 8'h40, 16'h0));
        q_gnt.push_back(ev(0, t + 1, 1'b0, 8'h0, 16'h0));
        q_rv.push_back(ev(0, t + 3, 1'b0, 8'h0, 16'h1234));
        wait_gnt(0);
        dbg_req[0] = 1'b0;
        repeat (4) tick();

        // CPU read back 0x12: ack t+3 with the word written earlier.
        cpu_cs[0] = 1'b1; cpu_rw_[0] = 1'b1; cpu_addr[0] = 8'h12;
        t = cyc;
        q_mem.push_back(ev(0, t + 1, 1'b1, 8'h12, 16'h0));
        q_ack.push_back(ev(0, t + 3, 1'b0, 8'h0, 16'hBEEF));
        repeat (2) tick();
        check("rd stall wait", 64'(cpu_stall[0]), 64'd1);
        tick();
        cpu_cs[0] = 1'b0;
        repeat (3) tick();

        // Contention after reset: CPU first, then strict CPU/DBG alternation.
        pulse_reset();
        cpu_cs[0] = 1'b1; cpu_rw_[0] = 1'b0; cpu_addr[0] = 8'h20; cpu_wdata[0] = 16'hC000;
        dbg_req[0] = 1'b1; dbg_rw_[0] = 1'b0; dbg_addr[0] = 8'h30; dbg_wdata[0] = 16'hD000;
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            q_mem.push_back(ev(0, t + 1 + 4*k, 1'b0, 8'(8'h20 + k), 16'(16'hC000 + k)));
            q_mem.push_back(ev(0, t + 3 + 4*k, 1'b0, 8'(8'h30 + k), 16'(16'hD000 + k)));
            q_gnt.push_back(ev(0, t + 3 + 4*k, 1'b0, 8'h0, 16'h0));
            q_ack.push_back(ev(0, t + 2 + 4*k, 1'b0, 8'h0, 16'h0000));
        end
        nc = 0; nd = 0; n = 0;
        while ((nc < 3 || nd < 3) && n < 40) begin
            tick();
            n++;
            if (cpu_ack[0]) begin
                nc++;
                if (nc < 3) begin
                    cpu_addr[0] = 8'(8'h20 + nc); cpu_wdata[0] = 16'(16'hC000 + nc);
                end else cpu_cs[0] = 1'b0;
            end
            if (dbg_gnt[0]) begin
                nd++;
                if (nd < 3) begin
                    dbg_addr[0] = 8'(8'h30 + nd); dbg_wdata[0] = 16'(16'hD000 + nd);
                end else dbg_req[0] = 1'b0;
            end
        end
        if (nc < 3 || nd < 3) fail_now("contention timeout", 64'({nc, nd}));
        idle_inputs();
        repeat (3) tick();

        // Halt during a CPU read on the RD_LAT=3 instance.
        cpu_cs[1] = 1'b1; cpu_rw_[1] = 1'b1; cpu_addr[1] = 8'h55;
        t = cyc;
        q_mem.push_back(ev(1, t + 1, 1'b1, 8'h55, 16'h0));
        q_ack.push_back(ev(1, t + 5, 1'b0, 8'h0, 16'hA5A5));
        repeat (2) tick();                       // t+2, in WAIT
        dbg_halt[1] = 1'b1;
        repeat (2) tick();                       // t+4
        check("halted in wait", 64'(halted[1]), 64'd0);
        tick();                                  // t+5, ack cycle
        check("halted at ack", 64'(halted[1]), 64'd0);
        cpu_cs[1] = 1'b0;
        tick();                                  // t+6
        check("halted after ack", 64'(halted[1]), 64'd1);
        cpu_cs[1] = 1'b1; cpu_rw_[1] = 1'b1; cpu_addr[1] = 8'h56;
        tick();                                  // t+7
        check("halt stall", 64'(cpu_stall[1]), 64'd1);
        dbg_req[1] = 1'b1; dbg_rw_[1] = 1'b0; dbg_addr[1] = 8'h60; dbg_wdata[1] = 16'h7777;
        q_mem.push_back(ev(1, t + 8, 1'b0, 8'h60, 16'h7777));
        q_gnt.push_back(ev(1, t + 8, 1'b0, 8'h0, 16'h0));
        tick();                                  // t+8, debug issue
        dbg_req[1] = 1'b0;
        tick();                                  // t+9
        check("halted during dbg", 64'(halted[1]), 64'd1);
        tick();                                  // t+10
        dbg_halt[1] = 1'b0;
        q_mem.push_back(ev(1, t + 11, 1'b1, 8'h56, 16'h0));
        q_ack.push_back(ev(1, t + 15, 1'b0, 8'h0, 16'h0F0F));
        tick();                                  // t+11
        check("halted released", 64'(halted[1]), 64'd0);
        repeat (3) tick();                       // t+14
        check("post-halt stall", 64'(cpu_stall[1]), 64'd1);
        tick();                                  // t+15
        cpu_cs[1] = 1'b0;
        repeat (2) tick();

        // Debug read back of the write made while halted: rvalid at s+5.
        dbg_req[1] = 1'b1; dbg_rw_[1] = 1'b1; dbg_addr[1] = 8'h60;
        t = cyc;
        q_mem.push_back(ev(1, t + 1, 1'b1, 8'h60, 16'h0));
        q_gnt.push_back(ev(1, t + 1, 1'b0, 8'h0, 16'h0));
        q_rv.push_back(ev(1, t + 5, 1'b0, 8'h0, 16'h7777));
        wait_gnt(1);
        dbg_req[1] = 1'b0;
        repeat (6) tick();

        // Reset during WAIT: access abandoned, no ack, next request works.
        cpu_cs[1] = 1'b1; cpu_rw_[1] = 1'b1; cpu_addr[1] = 8'h55;
        t = cyc;
        q_mem.push_back(ev(1, t + 1, 1'b1, 8'h55, 16'h0));
        repeat (2) tick();                       // t+2, in WAIT
        reset = 1'b0;
        cpu_cs[1] = 1'b0;
        tick();                                  // t+3
        check("wait-rst mem_cs",    64'(mem_cs[1]),    64'd0);
        check("wait-rst cpu_ack",   64'(cpu_ack[1]),   64'd0);
        check("wait-rst cpu_rdata", 64'(cpu_rdata[1]), 64'd0);
        reset = 1'b1;
        repeat (2) tick();
        cpu_cs[1] = 1'b1; cpu_rw_[1] = 1'b1; cpu_addr[1] = 8'h56;
        t = cyc;
        q_mem.push_back(ev(1, t + 1, 1'b1, 8'h56, 16'h0));
        q_ack.push_back(ev(1, t + 5, 1'b0, 8'h0, 16'h0F0F));
        repeat (5) tick();
        cpu_cs[1] = 1'b0;
        repeat (4) tick();

        // Anything still queued is an event the DUT never produced.
        while (q_mem.size() > 0) begin
            mon_e = q_mem.pop_front();
            fail_now("missing mem_cs", pack(mon_e.dut, mon_e.cyc, mon_e.rw, mon_e.addr, mon_e.data));
        end
        while (q_gnt.size() > 0) begin
            mon_e = q_gnt.pop_front();
            fail_now("missing dbg_gnt", pack(mon_e.dut, mon_e.cyc, 1'b0, 8'h0, 16'h0));
        end
        while (q_ack.size() > 0) begin
            mon_e = q_ack.pop_front();
            fail_now("missing cpu_ack", pack(mon_e.dut, mon_e.cyc, 1'b0, 8'h0, mon_e.data));
        end
        while (q_rv.size() > 0) begin
            mon_e = q_rv.pop_front();
            fail_now("missing dbg_rvalid", pack(mon_e.dut, mon_e.cyc, 1'b0, 8'h0, mon_e.data));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the CPU datapath's load/store path and a debug/loader port (program load, memory inspection). It sequences each access as issue, then wait for read latency, then return data. It stalls the CPU while its access is pending or lost arbitration. A debug halt lets the host own memory exclusively between CPU accesses. It sits between the datapath's d_mem_cs/d_mem_rw_ signals and the dmem instance, on clk_slow.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 16, data word width
RD_LAT, 1, cycles from mem_cs cycle to mem_rdata valid (legal 1..7)

Ports:
clk  in  1  clock (clk_slow domain)
reset  in  1  synchronous, active-low reset
cpu_cs  in  1  CPU memory access request (level, held until serviced)
cpu_rw_  in  1  1 = read, 0 = write
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse for the CPU access
cpu_stall  out  1  freeze CPU (gates pc_load/rf_write_en upstream)
dbg_req  in  1  debug access request (level, held until dbg_gnt)
dbg_rw_  in  1  1 = read, 0 = write
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  one-cycle pulse in the debug access's issue cycle
dbg_rdata  out  DATA_W  debug read data, valid when dbg_rvalid=1
dbg_rvalid  out  1  one-cycle debug read-data pulse
dbg_halt  in  1  host request to lock the CPU out of memory
halted  out  1  CPU locked out and no CPU access in flight
mem_cs  out  1  memory chip select, one-cycle pulse per access
mem_rw_  out  1  1 = read, 0 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-low; reset=0 sampled on a clk edge resets the block.
- Reset values:
  - mem_cs=0, mem_rw_=1, mem_addr=0, mem_wdata=0.
  - cpu_ack=0, dbg_gnt=0, dbg_rvalid=0.
  - cpu_rdata=0, dbg_rdata=0, halted=0.
  - FSM=IDLE, last_owner=DBG, so the CPU wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample eligible requests. CPU is eligible if cpu_cs=1, dbg_halt=0 and cpu_ack=0 in this cycle (the ack cycle is masked). Debug is eligible if dbg_req=1.
  - Neither eligible: stay in IDLE.
  - One eligible: it wins.
  - Both eligible: the requester other than last_owner wins (round-robin). last_owner updates to the winner.
  - Winner's rw_/addr/wdata are registered; go to ISSUE.
- ISSUE (cycle t+1 after sampling at t):
  - mem_cs=1 with the registered command; dbg_gnt=1 if the owner is debug.
  - Write: go to DONE.
  - Read: load a latency counter with RD_LAT; go to WAIT.
- WAIT: decrement the counter. When mem_rdata is valid (cycle t+1+RD_LAT), capture it into the owner's rdata register; go to DONE.
- DONE (write t+2, read t+2+RD_LAT):
  - Owner CPU: cpu_ack=1 for one cycle, cpu_rdata holds the captured word.
  - Owner debug, read only: dbg_rvalid=1 for one cycle.
  - Behaves as IDLE in the same cycle (samples requests), so back-to-back issue is possible.
- Outside their access, mem_cs=0 and mem_rw_=1; mem_addr and mem_wdata hold their last values. cpu_rdata and dbg_rdata hold until overwritten.
- cpu_stall is combinational: cpu_cs & ~cpu_ack.
  - High through sampling, issue and wait, and indefinitely while halted or losing arbitration.
  - Low in the ack cycle.
- Debug must hold req and command stable until dbg_gnt. If dbg_req is still high when the FSM next samples, it is a new access.
- dbg_halt:
  - Blocks new CPU grants immediately.
  - A CPU access already past sampling completes normally.
  - halted = dbg_halt & (no CPU access in ISSUE/WAIT/DONE), registered: rises the cycle after the in-flight access's DONE, or one cycle after dbg_halt if none.
  - Deasserting dbg_halt drops halted next cycle; the pending cpu_cs is eligible immediately.
- Reset mid-operation: in-flight access abandoned, no ack/rvalid, mem_cs=0 next cycle.

Test Plan:
- Reset: hold reset=0 with cpu_cs=1 and dbg_req=1 -> mem_cs=0, cpu_ack=0, dbg_gnt=0, halted=0, cpu_rdata=0.
- CPU write: cpu_cs=1, cpu_rw_=0, addr 0x12, data 0xBEEF sampled at t -> mem_cs=1, mem_rw_=0, mem_addr 0x12, mem_wdata 0xBEEF at t+1; cpu_ack=1 and cpu_stall=0 at t+2; no second write.
- Debug read, RD_LAT=1: dbg_req read 0x40 at t, memory returns 0x1234 at t+2 -> dbg_gnt at t+1; dbg_rvalid=1, dbg_rdata=0x1234 at t+3.
- Contention: after reset, CPU and debug both request writes continuously -> CPU issued first, then alternating CPU/DBG; neither starves.
- Halt: dbg_halt raised during a CPU read (RD_LAT=3) -> read completes with cpu_ack; halted rises next cycle; a new cpu_cs stalls with no mem_cs; debug writes proceed; dbg_halt lowered -> CPU issued within 2 cycles.
- Reset during WAIT: reset=0 one cycle -> no cpu_ack/dbg_rvalid; FSM in IDLE; next request serviced normally.
